synch_fifo_param: RTL
=====================

// Module: synch_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO: next generation of the team's synchronous FIFO.
//  Adds configurable width/depth, almost-full/empty thresholds, overflow/underflow error pulses,
//  synchronous flush and an optional first-word-fall-through (FWFT) read mode.
//  Sits between producer/consumer blocks sharing one clock domain.
// PARAMETERS
//  DATA_W     16        data word width in bits (>=1)
//  DEPTH      32        number of entries; power of two, >=4
//  AF_THRESH  DEPTH-4   almost_full asserts when fifo_count >= AF_THRESH
//  AE_THRESH  4         almost_empty asserts when fifo_count <= AE_THRESH
//  FWFT       0         0 = standard read (1-cycle latency); 1 = first-word-fall-through
// PORTS
//  clk           in   1                 rising-edge clock
//  rst           in   1                 synchronous reset, active-low (sampled on clk)
//  clr           in   1                 synchronous flush, active-high; empties FIFO, memory untouched
//  wr_en         in   1                 write request
//  data_in       in   DATA_W            write data
//  rd_en         in   1                 read request (FWFT: pop of head)
//  data_out      out  DATA_W            read data
//  full_flag     out  1                 fifo_count == DEPTH
//  empty_flag    out  1                 fifo_count == 0
//  almost_full   out  1                 fifo_count >= AF_THRESH
//  almost_empty  out  1                 fifo_count <= AE_THRESH
//  fifo_count    out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//  overflow      out  1                 1-cycle pulse: write rejected (full)
//  underflow     out  1                 1-cycle pulse: read rejected (empty)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): wr_ptr=rd_ptr=0, fifo_count=0, data_out=0, empty_flag=1,
//    almost_empty=1, full_flag=0, almost_full=0, overflow=0, underflow=0. rst has priority over clr.
//  - clr==1: same as reset except data_out holds its value; wr_en/rd_en ignored that cycle.
//  - Write accepted iff wr_en && (!full_flag || rd accepted same cycle); stored at wr_ptr, wr_ptr++.
//  - Read accepted iff rd_en && !empty_flag; rd_ptr++.
//  - Pointers are $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally; count tracks occupancy:
//    +1 on write-only, -1 on read-only, unchanged on both/neither.
//  - All flags are registered, derived from next-state count: valid the cycle after the change.
//  - Standard mode (FWFT=0): data_out <= mem[rd_ptr] on accepted read; visible 1 cycle after rd_en.
//    data_out holds its last value when no read is accepted.
//  - FWFT mode (FWFT=1): data_out = mem[rd_ptr] whenever !empty_flag (0 latency); rd_en pops.
//    When empty, data_out holds the last popped word.
//  - Simultaneous wr+rd when empty: write accepted, read rejected, underflow=1, count 0->1.
//  - Simultaneous wr+rd when full: both accepted, count stays DEPTH, no overflow.
//  - overflow=1 for one cycle when wr_en && full_flag && no read accepted; data dropped.
//  - underflow=1 for one cycle when rd_en && empty_flag; pointers/data_out unchanged.
//  - Reset or clr mid-stream discards all contents; first write after it lands at address 0.
// TESTING
//  1. Reset: hold rst=0 2 cycles with wr_en=1 -> count=0, empty_flag=1, data_out=0, no write taken.
//  2. Write 68,123,53 then read 3 (FWFT=0) -> data_out 68,123,53 each 1 cycle after rd_en;
//     count 3->0, empty_flag=1 after last.
//  3. Fill 32 words (0..31) -> almost_full at count 28, full_flag at 32; 33rd write -> overflow pulse,
//     count stays 32; drain -> 0..31 in order (wrap-around checked).
//  4. At full, wr_en=rd_en=1 with data_in=9 for 5 cycles -> count stays 32, no overflow,
//     9 read back after original 32 entries.
//  5. Empty FIFO, rd_en=1 -> underflow pulse 1 cycle; wr_en=rd_en=1 data_in=9 -> count=1, underflow=1.
//  6. FWFT=1: write 0xA5A5 -> data_out=0xA5A5 cycle after write with empty_flag=0;
//     rd_en pops; clr mid-fill of 10 -> count=0 next cycle.

Source files
------------

// File: rtl/synch_fifo_param.sv
// Parametrised single-clock FIFO with registered status flags, error pulses,
// synchronous flush and an optional first-word-fall-through read port.
module synch_fifo_param #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter bit FWFT      = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       data_out,
  output logic                    full_flag,
  output logic                    empty_flag,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dataOut_q;
  logic              full_q, empty_q, almostFull_q, almostEmpty_q;
  logic              overflow_q, underflow_q;
  logic              rdAccept, wrAccept;

  always_comb begin
    rdAccept = rd_en && !empty_q;
    wrAccept = wr_en && (!full_q || rdAccept);
    wrPtr_d  = wrAccept ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d  = rdAccept ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d  = count_q;
    if (wrAccept && !rdAccept) begin
      count_d = count_q + CNT_W'(1);
    end else if (rdAccept && !wrAccept) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage is never cleared; reset and flush only move the pointers.
  always_ff @(posedge clk) begin
    if (rst && !clr && wrAccept) begin
      mem_q[wrPtr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      dataOut_q     <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almostFull_q  <= 1'b0;
      almostEmpty_q <= 1'b1;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else if (clr) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almostFull_q  <= 1'b0;
      almostEmpty_q <= 1'b1;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      full_q        <= (count_d == FULL_CNT);
      empty_q       <= (count_d == '0);
      almostFull_q  <= (count_d >= AF_CNT);
      almostEmpty_q <= (count_d <= AE_CNT);
      overflow_q    <= wr_en && full_q && !rdAccept;
      underflow_q   <= rd_en && empty_q;
      if (rdAccept) begin
        dataOut_q <= mem_q[rdPtr_q];
      end
    end
  end

  // In FWFT mode dataOut_q keeps the last popped word for display while empty.
  generate
    if (FWFT) begin : g_fwft
      assign data_out = empty_q ? dataOut_q : mem_q[rdPtr_q];
    end else begin : g_std
      assign data_out = dataOut_q;
    end
  endgenerate

  assign full_flag    = full_q;
  assign empty_flag   = empty_q;
  assign almost_full  = almostFull_q;
  assign almost_empty = almostEmpty_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
